// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side hazard signals seen by hazard_stall_ctrl; HAZARD_PERF_CNT_EN adds stall_cycles.
// Zero-latency bundle; no backpressure of its own, stalls are the flow control.
interface hazard_stall_ctrl_if #(
  parameter int PERF_W = 32
);
  logic [4:0] rs1D;
  logic [4:0] rs2D;
  logic       uses_rs1D;
  logic       uses_rs2D;
  logic [4:0] rdE;
  logic       writesregE;
  logic       memtoregE;
  logic       pc_srcE;
  logic       memreqM;
  logic       memackM;
  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       stallM;
  logic       flushD;
  logic       flushE;
  logic       flushW;
  logic       err_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cycles;
`endif

  // Pipeline side: supplies hazard sources, consumes enables/clears.
  modport master (
    output rs1D, rs2D, uses_rs1D, uses_rs2D, rdE, writesregE, memtoregE,
    output pc_srcE, memreqM, memackM,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushW, err_timeout
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cycles
`endif
  );

  modport slave (
    input  rs1D, rs2D, uses_rs1D, uses_rs2D, rdE, writesregE, memtoregE,
    input  pc_srcE, memreqM, memackM,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushW, err_timeout
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cycles
`endif
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch / multi-cycle-memory stall+flush controller with memory-wait watchdog (HAZARD_PERF_CNT_EN: stall counter).
// Stall/flush outputs are combinational (0 cycles); memory wait freezes F..M until memackM.
module hazard_stall_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
`ifdef HAZARD_PERF_CNT_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_stall_ctrl_if.slave hz
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic lwstall;
  logic memstall;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;

  // Register 0 is hardwired zero, so a "write" to it never creates a dependency.
  assign lwstall = hz.memtoregE && hz.writesregE && (hz.rdE != 5'd0) &&
                   ((hz.uses_rs1D && (hz.rs1D == hz.rdE)) ||
                    (hz.uses_rs2D && (hz.rs2D == hz.rdE)));

  assign memstall = ((state_q == MEM_WAIT) || hz.memreqM) && !hz.memackM;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      RUN: begin
        if (hz.memreqM && !hz.memackM) begin
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.memackM) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == TIMEOUT_C) err_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Memory freeze masks branch and load-use; both are re-evaluated once the freeze lifts.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!rst_n) begin
      stall_f = 1'b0;
    end else if (memstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.pc_srcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lwstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] perf_q, perf_d;

  assign perf_d = stall_f ? perf_q + PERF_W'(1) : perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign hz.stall_cycles = perf_q;
`endif

  assign hz.stallF      = stall_f;
  assign hz.stallD      = stall_d;
  assign hz.stallE      = stall_e;
  assign hz.stallM      = stall_m;
  assign hz.flushD      = flush_d;
  assign hz.flushE      = flush_e;
  assign hz.flushW      = flush_w;
  assign hz.err_timeout = err_q;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Stall/flush controller; complements the EX-stage forwarding logic.
- Covers the hazards that forwarding cannot resolve:
  - load-use RAW: stall F/D one cycle, bubble into E;
  - taken branch/jump resolved in E: flush D and E;
  - multi-cycle data memory: freeze F..M until the memory acknowledges, bubble into W.
- Sits beside the pipeline registers and drives their enable/clear inputs.
- Also carries a memory-wait timeout watchdog.

Parameters:
- TIMEOUT, 255, max MEM_WAIT cycles before err_timeout sets (1..2^CNT_W-1).
- CNT_W, 8, width of the wait counter.
- PERF_W, 32, width of the stall performance counter (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1D  in  5  source reg 1 of instruction in Decode.
- rs2D  in  5  source reg 2 of instruction in Decode.
- uses_rs1D  in  1  Decode instruction reads rs1.
- uses_rs2D  in  1  Decode instruction reads rs2.
- rdE  in  5  destination reg of instruction in Execute.
- writesregE  in  1  Execute instruction writes rdE.
- memtoregE  in  1  Execute instruction is a load.
- pc_srcE  in  1  taken branch/jump resolved in Execute.
- memreqM  in  1  Memory-stage instruction issues data-memory access.
- memackM  in  1  data memory completes the access this cycle.
- stallF  out  1  hold PC.
- stallD  out  1  hold IF/ID register.
- stallE  out  1  hold ID/EX register.
- stallM  out  1  hold EX/MEM register.
- flushD  out  1  clear IF/ID register.
- flushE  out  1  clear ID/EX register.
- flushW  out  1  clear MEM/WB register (insert bubble).
- err_timeout  out  1  sticky memory-timeout flag.

Behaviour:
- State register: RUN or MEM_WAIT. Wait counter is CNT_W bits. err_timeout is a register.
- Async reset (rst_n=0):
  - state=RUN, counter=0, err_timeout=0;
  - all stall/flush outputs forced to 0 while rst_n=0.
- Reset mid-MEM_WAIT abandons the wait; pipeline restarts in RUN.
- All stall/flush outputs are combinational from state and current inputs (zero latency). State and counter update on the rising edge.
- Definitions:
  - lwstall = memtoregE & writesregE & (rdE!=0) & ((uses_rs1D & rs1D==rdE) | (uses_rs2D & rs2D==rdE)).
  - memstall = (state==MEM_WAIT | memreqM) & !memackM.
- Priority, highest first:
  1. memstall: stallF=stallD=stallE=stallM=1, flushW=1; flushD=flushE=0 (branch/load-use held, re-evaluated after release).
  2. pc_srcE: flushD=1, flushE=1, no stalls. Overrides lwstall because the Decode instruction is wrong-path.
  3. lwstall: stallF=stallD=1, flushE=1.
  4. Otherwise all outputs 0.
- FSM transitions:
  - RUN: memreqM & !memackM -> MEM_WAIT, counter<=1. memreqM & memackM same cycle -> stay RUN, no stall.
  - MEM_WAIT, memackM=1: stalls drop that cycle -> RUN, counter<=0.
  - MEM_WAIT, memackM=0: counter increments, saturating at 2^CNT_W-1. When counter==TIMEOUT, err_timeout<=1 (sticky until reset). The FSM keeps waiting.
- memackM while in RUN with memreqM=0 is ignored.
- rd/rs index 0 never causes a load-use stall.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - adds output stall_cycles[PERF_W-1:0], reset 0;
  - increments each cycle stallF=1;
  - wraps at 2^PERF_W.
- Undefined: port and counter absent. All other behaviour identical.

Test Plan:
- Load-use: memtoregE=1, writesregE=1, rdE=5, rs2D=5, uses_rs2D=1 -> stallF=stallD=flushE=1 for exactly one cycle. With rdE=0 instead -> all outputs 0.
- Branch vs load-use: pc_srcE=1 with the lwstall conditions above -> flushD=flushE=1, stallF=stallD=0.
- Mem wait: memreqM=1, memackM=0 for 3 cycles, then memackM=1 -> stallF/D/E/M=1 and flushW=1 for 3 cycles, all 0 on the ack cycle, state back to RUN. Same-cycle ack -> no stall.
- Mem wait dominates: memstall with pc_srcE=1 -> flushD=flushE=0. After ack, pc_srcE=1 -> flushD=flushE=1.
- Timeout: TIMEOUT=4, memackM held 0 -> err_timeout rises after the 4th wait cycle and stays 1 after a later ack. rst_n pulse low mid-wait -> outputs 0 immediately, err_timeout=0, state RUN.
- With HAZARD_PERF_CNT_EN defined: 1 load-use stall + 3-cycle mem wait -> stall_cycles=4.
